// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo tester: FSM state encoding, LFSR taps and default seed.
package uart_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SEND      = 3'd1;
  localparam logic [2:0] ST_WAIT_ECHO = 3'd2;
  localparam logic [2:0] ST_NEXT      = 3'd3;
  localparam logic [2:0] ST_REPORT    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_SEND      = ST_SEND,
    S_WAIT_ECHO = ST_WAIT_ECHO,
    S_NEXT      = ST_NEXT,
    S_REPORT    = ST_REPORT
  } state_t;

  // Feedback taps q7^q5^q4^q3 give a maximal-length (255) sequence.
  localparam logic [7:0] LFSR_TAPS    = 8'hB8;
  localparam logic [7:0] DEFAULT_SEED = 8'hA5;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

  // The all-zero state is a lock-up state, so a zero seed is replaced by 1.
  function automatic logic [7:0] fix_seed(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

endpackage

// File: rtl/uart_echo_tester_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous load and step; load has priority over step.
module lfsr8 import uart_pkg::*; #(
  parameter logic [7:0] RESET_SEED = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= fix_seed(RESET_SEED);
    end else if (load) begin
      q <= fix_seed(seed);
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/uart_echo_tester.sv
// Sends an LFSR byte sequence through uart_tx and checks each echo from uart_rx,
// counting mismatches and timeouts and reporting pass/fail at the end of a run.
//
// state      | meaning
// IDLE       | waiting for start; results of the last run held
// SEND       | waiting for uart_tx idle, then pulse tx_dv with the next byte
// WAIT_ECHO  | waiting for the echo or the timeout
// NEXT       | advance LFSR and byte index
// REPORT     | pulse done, publish pass
module uart_echo_tester import uart_pkg::*; #(
  parameter int         CLKS_PER_BIT = 87,
  parameter int         NUM_BYTES    = 16,
  parameter int         TIMEOUT_CLKS = 24 * CLKS_PER_BIT,
  parameter logic [7:0] SEED         = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       tx_dv,
  output logic [7:0] tx_byte,
  input  logic       tx_active,
  input  logic       rx_dv,
  input  logic [7:0] rx_byte,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] to_count,
  output logic [7:0] last_rx
);

  localparam int            TW       = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    LAST_IDX = 8'(NUM_BYTES - 1);

  state_t        state;
  logic [TW-1:0] to_cnt;
  logic [7:0]    idx;
  logic [7:0]    lfsr_q;
  logic          lfsr_load;
  logic          lfsr_step;

  assign lfsr_load = (state == S_IDLE) && start;
  assign lfsr_step = (state == S_NEXT);

  lfsr8 #(.RESET_SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (SEED),
    .step  (lfsr_step),
    .q     (lfsr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tx_dv     <= 1'b0;
      tx_byte   <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 8'h00;
      to_count  <= 8'h00;
      last_rx   <= 8'h00;
      idx       <= 8'h00;
      to_cnt    <= '0;
    end else begin
      tx_dv <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            err_count <= 8'h00;
            to_count  <= 8'h00;
            pass      <= 1'b0;
            idx       <= 8'h00;
            busy      <= 1'b1;
            state     <= S_SEND;
          end
        end
        // Any rx_dv here is a stale or late echo and is dropped.
        S_SEND: begin
          if (!tx_active) begin
            tx_byte <= lfsr_q;
            tx_dv   <= 1'b1;
            to_cnt  <= '0;
            state   <= S_WAIT_ECHO;
          end
        end
        // An echo on the expiry cycle takes priority over the timeout.
        S_WAIT_ECHO: begin
          if (rx_dv) begin
            last_rx <= rx_byte;
            if (rx_byte != tx_byte && err_count != 8'hFF)
              err_count <= err_count + 8'd1;
            state <= S_NEXT;
          end else if (to_cnt == TO_LAST) begin
            if (to_count != 8'hFF)
              to_count <= to_count + 8'd1;
            state <= S_NEXT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_NEXT: begin
          idx   <= idx + 8'd1;
          state <= (idx == LAST_IDX) ? S_REPORT : S_SEND;
        end
        S_REPORT: begin
          done  <= 1'b1;
          pass  <= (err_count == 8'h00) && (to_count == 8'h00);
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
